uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//   Serial-to-byte receiver for 8N1 asynchronous serial. Consumes the line driven by
//   the uart_byte_tx stage (loopback or external RS-232 pin) and presents each byte
//   with a one-cycle done strobe. Uses 16x oversampling with 3-sample majority voting,
//   false-start rejection and stop-bit framing check.
//   Baud table matches the transmitter: 50 MHz Clk.
// PARAMETERS
//   SYNC_STAGES   2   synchroniser flops on Rs232_Rx (>=2)
//   FE_DISCARD    0   1: suppress Rx_Done on framing error; Frame_Err still pulses
// PORTS
//   Clk         in   1  system clock, 50 MHz
//   Rst         in   1  asynchronous, active-high reset
//   Rs232_Rx    in   1  serial line, idle high, asynchronous to Clk
//   baud_set    in   3  0:9600 1:19200 2:38400 3:57600 4:115200, others:9600
//   data_byte   out  8  last received byte, LSB first on line
//   Rx_Done     out  1  one-cycle strobe, data_byte valid from this cycle
//   Frame_Err   out  1  one-cycle strobe with/instead of Rx_Done; stop bit sampled 0
//   uart_state  out  1  high from accepted start edge until stop-bit decision
// BEHAVIOUR
//   Reset: data_byte=0, Rx_Done=0, Frame_Err=0, uart_state=0, FSM=IDLE, counters=0.
//     Synchroniser flops reset to 1. Edge-history flop resets to 0, so no start is armed
//     until the line has been seen high.
//   Tick gen: div_cnt counts 0..sample_DR, then wraps and emits tick.
//     sample_DR: 0:324 1:162 2:80 3:53 4:26.
//     sample_DR is reloaded from baud_set only in IDLE; a change mid-frame has no effect.
//     div_cnt is held at 0 in IDLE.
//   Start detect: falling edge on the synchronised line (prev=1, cur=0) in IDLE.
//     Enter START, clear div_cnt and tick_cnt. Set uart_state=1 the next cycle.
//   Per bit: tick_cnt counts 0..15. Samples are taken at ticks 7, 8 and 9.
//     bit value = majority(3). At tick 15 the FSM advances to the next bit.
//   FSM:
//     IDLE  -> START on start edge.
//     START -> IDLE at tick 9 if vote=1: false start, no strobe, uart_state=0.
//              Otherwise -> DATA at tick 15.
//     DATA  -> 8 bits. bit_cnt 0..7 shifts into a shift reg LSB first.
//              -> STOP after bit 7 at tick 15.
//     STOP  -> decided at tick 9 vote:
//              vote=1: data_byte<=shift, Rx_Done=1.
//              vote=0: Frame_Err=1. data_byte<=shift and Rx_Done=1 only if FE_DISCARD=0.
//              Same cycle: uart_state<=0, FSM->IDLE.
//              Leaving at mid-stop allows back-to-back frames and absorbs up to ~3% clock skew.
//   Latency: Rx_Done rises SYNC_STAGES + 1 cycles after the stop-bit tick-9 sample edge.
//     That is ~9.56 bit times after the line falling edge.
//   Strobes are single-cycle and never asserted outside STOP exit.
//   data_byte holds its value between frames.
//   Framing error: a stop sample of 0 with the line still low (break condition) must not
//     re-trigger a start. The edge detector needs the line high first.
//   Reset mid-frame: immediate abort to reset values. No strobe is emitted for the partial frame.
// TESTING
//   1. baud_set=0, uart_byte_tx loopback sends 0xA5 -> one Rx_Done, data_byte=0xA5, Frame_Err=0.
//   2. baud_set=4, back-to-back 0x00,0xFF,0x55 with no idle gap -> 3 Rx_Done in order,
//      data_byte matches each.
//   3. baud_set=0, line low for 4 ticks (~1300 clk), then high -> uart_state pulses,
//      no Rx_Done, no Frame_Err.
//   4. baud_set=2, 0x3C with stop bit forced 0 -> FE_DISCARD=0: Rx_Done+Frame_Err same cycle,
//      data_byte=0x3C. FE_DISCARD=1: Frame_Err only, data_byte unchanged.
//   5. Rst asserted during data bit 4, released with line low, line then high, then 0x81 sent
//      -> all outputs 0 during reset, single Rx_Done with 0x81.
//   6. baud_set 0->4 changed mid-frame of 0x5A at 9600 -> 0x5A decoded correctly.
//      Next frame at 115200 decodes correctly.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial-to-byte receiver with 16x oversampling.
//   Each bit is split into 16 ticks. Samples are taken at ticks 7, 8 and 9, and the bit
//   value is the 2-of-3 majority. A start bit that votes high is rejected as a false start.
//   The stop bit is judged at its tick 9, so the receiver is back in idle before the next
//   start edge can arrive.
// Parameters:
//   SYNC_STAGES  synchroniser depth on Rs232_Rx (>= 2)
//   FE_DISCARD   1: a framing error pulses Frame_Err only; 0: Rx_Done + data_byte update too
// Ports:
//   Clk         in   system clock (50 MHz)
//   Rst         in   asynchronous active-high reset
//   Rs232_Rx    in   serial line, idle high, asynchronous to Clk
//   baud_set    in   0:9600 1:19200 2:38400 3:57600 4:115200, others 9600
//   data_byte   out  last received byte
//   Rx_Done     out  one-cycle strobe, data_byte valid from this cycle
//   Frame_Err   out  one-cycle strobe, stop bit sampled low
//   uart_state  out  high from accepted start edge until the stop-bit decision
module uart_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          FE_DISCARD  = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rs232_Rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       Frame_Err,
    output logic       uart_state
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic [8:0]             div_cnt_q, div_cnt_d;
    logic [8:0]             sample_dr_q, sample_dr_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_byte_q, data_byte_d;
    logic                   rx_done_q, rx_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   uart_state_q, uart_state_d;

    logic       rx_s;
    logic       start_edge;
    logic       tick;
    logic       vote;
    logic [8:0] baud_dr;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = prev_q & ~rx_s;
    assign tick       = (div_cnt_q == sample_dr_q);
    // smp_q[0] holds tick 7, smp_q[1] tick 8; the live synchronised line is tick 9.
    assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        case (baud_set)
            3'd1:    baud_dr = 9'd162;
            3'd2:    baud_dr = 9'd80;
            3'd3:    baud_dr = 9'd53;
            3'd4:    baud_dr = 9'd26;
            default: baud_dr = 9'd324;
        endcase
    end

    // Synchroniser and edge history. fill_q marks when the chain holds real line samples;
    // until then prev_q stays 0 so the reset value of the chain cannot fake a high line
    // and arm a start when reset is released with the line low.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q <= '1;
            fill_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Rs232_Rx};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= fill_q[SYNC_STAGES-1] & rx_s;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        sample_dr_d  = sample_dr_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        smp_d        = smp_q;
        shift_d      = shift_q;
        data_byte_d  = data_byte_q;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
        uart_state_d = uart_state_q;

        if (state_q == StIdle) begin
            div_cnt_d   = '0;
            tick_cnt_d  = '0;
            bit_cnt_d   = '0;
            sample_dr_d = baud_dr;
            if (start_edge) begin
                state_d      = StStart;
                uart_state_d = 1'b1;
            end
        end else if (!tick) begin
            div_cnt_d = div_cnt_q + 9'd1;
        end else begin
            div_cnt_d  = '0;
            tick_cnt_d = tick_cnt_q + 4'd1;  // wraps 15 -> 0 at the bit boundary
            if (tick_cnt_q == 4'd7) smp_d[0] = rx_s;
            if (tick_cnt_q == 4'd8) smp_d[1] = rx_s;
            case (state_q)
                StStart: begin
                    if (tick_cnt_q == 4'd9 && vote) begin
                        state_d      = StIdle;
                        uart_state_d = 1'b0;
                    end else if (tick_cnt_q == 4'd15) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    if (tick_cnt_q == 4'd9) shift_d = {vote, shift_q[7:1]};
                    if (tick_cnt_q == 4'd15) begin
                        if (bit_cnt_q == 3'd7) state_d = StStop;
                        else bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                StStop: begin
                    if (tick_cnt_q == 4'd9) begin
                        state_d      = StIdle;
                        uart_state_d = 1'b0;
                        if (vote || !FE_DISCARD) begin
                            data_byte_d = shift_q;
                            rx_done_d   = 1'b1;
                        end
                        frame_err_d = ~vote;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            sample_dr_q  <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            smp_q        <= '0;
            shift_q      <= '0;
            data_byte_q  <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            uart_state_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            sample_dr_q  <= sample_dr_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            smp_q        <= smp_d;
            shift_q      <= shift_d;
            data_byte_q  <= data_byte_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            uart_state_q <= uart_state_d;
        end
    end

    assign data_byte  = data_byte_q;
    assign Rx_Done    = rx_done_q;
    assign Frame_Err  = frame_err_q;
    assign uart_state = uart_state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: drives serial frames into two receivers (FE_DISCARD=0 and 1) sharing one
// line; expected strobe/data records are queued at stimulus time and a monitor pops them
// whenever a receiver strobes.
module tb_uart_byte_rx;

    typedef struct packed {
        logic       done;
        logic       fe;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [2:0] baud;
    logic [7:0] data0, data1;
    logic       done0, done1, fe0, fe1, st0, st1;

    int   checks   = 0;
    int   failures = 0;
    logic saw_state = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always #10 clk = ~clk;

    uart_byte_rx #(.SYNC_STAGES(2), .FE_DISCARD(1'b0)) u_dut0 (
        .Clk(clk), .Rst(rst), .Rs232_Rx(rx), .baud_set(baud),
        .data_byte(data0), .Rx_Done(done0), .Frame_Err(fe0), .uart_state(st0)
    );

    uart_byte_rx #(.SYNC_STAGES(2), .FE_DISCARD(1'b1)) u_dut1 (
        .Clk(clk), .Rst(rst), .Rs232_Rx(rx), .baud_set(baud),
        .data_byte(data1), .Rx_Done(done1), .Frame_Err(fe1), .uart_state(st1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_evt(input int idx, input exp_t act);
        exp_t req;
        if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe dut%0d: got done=%0b fe=%0b data=0x%0h, expected none",
                     idx, act.done, act.fe, act.data);
            return;
        end
        req = (idx == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("frame_dut%0d {done,fe,data}", idx), 32'(act), 32'(req));
    endtask

    // Monitor: every strobe from either receiver consumes one expected record.
    always @(negedge clk) begin
        if (!rst) begin
            if (done0 || fe0) check_evt(0, {done0, fe0, data0});
            if (done1 || fe1) check_evt(1, {done1, fe1, data1});
            if (st0) saw_state = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int bt, input logic stop_v);
        rx = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bt) @(negedge clk);
        end
        rx = stop_v;
        repeat (bt) @(negedge clk);
    endtask

    task automatic push_both(input exp_t e0, input exp_t e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        rx   = 1'b1;
        baud = 3'd0;
        repeat (5) @(negedge clk);
        check("reset data_byte", 32'(data0), 32'h0);
        check("reset Rx_Done", 32'(done0), 32'h0);
        check("reset Frame_Err", 32'(fe0), 32'h0);
        check("reset uart_state", 32'(st0), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 0xA5 at 9600 with baud_set switched to 115200 mid-frame.
        push_both({1'b1, 1'b0, 8'hA5}, {1'b1, 1'b0, 8'hA5});
        fork
            send_byte(8'hA5, 5208, 1'b1);
            begin
                repeat (3 * 5208) @(negedge clk);
                baud = 3'd4;
            end
        join
        repeat (300) @(negedge clk);

        // Back-to-back at 115200, no idle gap.
        push_both({1'b1, 1'b0, 8'h00}, {1'b1, 1'b0, 8'h00});
        push_both({1'b1, 1'b0, 8'hFF}, {1'b1, 1'b0, 8'hFF});
        push_both({1'b1, 1'b0, 8'h55}, {1'b1, 1'b0, 8'h55});
        send_byte(8'h00, 434, 1'b1);
        send_byte(8'hFF, 434, 1'b1);
        send_byte(8'h55, 434, 1'b1);
        repeat (300) @(negedge clk);

        // False start: 4 ticks low at 9600.
        baud = 3'd0;
        repeat (20) @(negedge clk);
        saw_state = 1'b0;
        rx = 1'b0;
        repeat (1300) @(negedge clk);
        rx = 1'b1;
        repeat (4000) @(negedge clk);
        check("false_start uart_state pulsed", 32'(saw_state), 32'h1);
        check("false_start uart_state back low", 32'(st0), 32'h0);

        // Framing error at 38400; line stays low past the stop bit, then returns high.
        baud = 3'd2;
        repeat (20) @(negedge clk);
        push_both({1'b1, 1'b1, 8'h3C}, {1'b0, 1'b1, 8'h55});
        send_byte(8'h3C, 1302, 1'b0);
        repeat (500) @(negedge clk);
        rx = 1'b1;
        repeat (500) @(negedge clk);

        // Reset during data bit 4, released with line low.
        baud = 3'd4;
        repeat (20) @(negedge clk);
        rx = 1'b0;
        repeat (5 * 434 + 217) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset data_byte", 32'(data0), 32'h0);
        check("midreset Rx_Done", 32'(done0), 32'h0);
        check("midreset Frame_Err", 32'(fe0), 32'h0);
        check("midreset uart_state", 32'(st0), 32'h0);
        check("midreset data_byte dut1", 32'(data1), 32'h0);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        rx = 1'b1;
        repeat (868) @(negedge clk);
        push_both({1'b1, 1'b0, 8'h81}, {1'b1, 1'b0, 8'h81});
        send_byte(8'h81, 434, 1'b1);
        repeat (300) @(negedge clk);
        check("data_byte holds after frame", 32'(data0), 32'h81);

        check("dut0 frames outstanding", 32'(q0.size()), 32'h0);
        check("dut1 frames outstanding", 32'(q1.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
